memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 29 ++
 rtl/memory_arbiter_sat_counter.sv | 35 +++
 rtl/memory_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states,
// grant encoding and the round-robin winner selection helper.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // A lone requester wins; under contention the port not granted last wins.
    function automatic grant_e pick_winner(input logic ireq, input logic dreq, input grant_e last);
        grant_e win;
        if (ireq && dreq) begin
            win = (last == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (ireq) begin
            win = GRANT_I;
        end else begin
            win = GRANT_D;
        end
        return win;
    endfunction

endpackage

// File: rtl/memory_arbiter_sat_counter.sv
// Saturating up-counter: increments on i_Inc and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Inc,
    output logic [WIDTH-1:0] o_Count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (i_Inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Count = count_q;

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory with a fixed
// three-cycle IDLE -> ACCESS -> RESP transaction and a contention counter.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_IReq,
    input  logic [ADDR_WIDTH-1:0]  i_IAddr,
    output logic                   o_IAck,
    output logic [DATA_WIDTH-1:0]  o_IRdData,
    input  logic                   i_DReq,
    input  logic                   i_DWrite,
    input  logic [ADDR_WIDTH-1:0]  i_DAddr,
    input  logic [DATA_WIDTH-1:0]  i_DWrData,
    output logic                   o_DAck,
    output logic [DATA_WIDTH-1:0]  o_DRdData,
    output logic                   o_MemReadEnable,
    output logic                   o_MemWriteEnable,
    output logic [ADDR_WIDTH-1:0]  o_MemAddr,
    output logic [DATA_WIDTH-1:0]  o_MemWrData,
    input  logic [DATA_WIDTH-1:0]  i_MemRdData,
    output logic [COUNT_WIDTH-1:0] o_ConflictCount
);

    arb_state_e             state_d, state_q;
    grant_e                 last_grant_d, last_grant_q;
    grant_e                 winner_d, winner_q;
    grant_e                 grant_s;
    logic                   wr_d, wr_q;
    logic                   mem_re_d, mem_re_q;
    logic                   mem_we_d, mem_we_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_d, mem_addr_q;
    logic [DATA_WIDTH-1:0]  mem_wdata_d, mem_wdata_q;
    logic                   iack_d, iack_q;
    logic                   dack_d, dack_q;
    logic                   conflict_s;

    assign grant_s    = pick_winner(i_IReq, i_DReq, last_grant_q);
    assign conflict_s = (state_q == IDLE) && i_IReq && i_DReq;

    // Next-state, grant latching and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        wr_d         = wr_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = {ADDR_WIDTH{1'b0}};
        mem_wdata_d  = {DATA_WIDTH{1'b0}};
        iack_d       = 1'b0;
        dack_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_IReq || i_DReq) begin
                    state_d      = ACCESS;
                    last_grant_d = grant_s;
                    winner_d     = grant_s;
                    if (grant_s == GRANT_I) begin
                        wr_d       = 1'b0;
                        mem_re_d   = 1'b1;
                        mem_addr_d = i_IAddr;
                    end else begin
                        wr_d       = i_DWrite;
                        mem_re_d   = !i_DWrite;
                        mem_we_d   = i_DWrite;
                        mem_addr_d = i_DAddr;
                        if (i_DWrite) begin
                            mem_wdata_d = i_DWrData;
                        end else begin
                            mem_wdata_d = {DATA_WIDTH{1'b0}};
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                iack_d  = (winner_q == GRANT_I);
                dack_d  = (winner_q == GRANT_D);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant history and output registers; reset forces everything idle at once.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            winner_q     <= GRANT_I;
            wr_q         <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q  <= {DATA_WIDTH{1'b0}};
            iack_q       <= 1'b0;
            dack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            wr_q         <= wr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            iack_q       <= iack_d;
            dack_q       <= dack_d;
        end
    end

    // Memory read data arrives during RESP, so it is gated through by the ack flop.
    always_comb begin
        o_IRdData = {DATA_WIDTH{1'b0}};
        o_DRdData = {DATA_WIDTH{1'b0}};
        if (iack_q) begin
            o_IRdData = i_MemRdData;
        end else begin
            o_IRdData = {DATA_WIDTH{1'b0}};
        end
        if (dack_q && !wr_q) begin
            o_DRdData = i_MemRdData;
        end else begin
            o_DRdData = {DATA_WIDTH{1'b0}};
        end
    end

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_conflict_cnt (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Inc   (conflict_s),
        .o_Count (o_ConflictCount)
    );

    assign o_IAck           = iack_q;
    assign o_DAck           = dack_q;
    assign o_MemReadEnable  = mem_re_q;
    assign o_MemWriteEnable = mem_we_q;
    assign o_MemAddr        = mem_addr_q;
    assign o_MemWrData      = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter: a default-width instance
// for the functional sequence and a COUNT_WIDTH=4 instance for saturation.
module tb_memory_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ireq, dreq, dwrite;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic        iack, dack, mre, mwe;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic [15:0] ccount;

    logic        s_rst_n;
    logic        s_iack, s_dack, s_mre, s_mwe;
    logic [31:0] s_irdata, s_drdata, s_maddr, s_mwdata;
    logic [3:0]  s_count;

    int checks = 0;
    int errors = 0;

    memory_arbiter u_dut (
        .i_Clock          (clk),
        .i_Reset          (rst_n),
        .i_IReq           (ireq),
        .i_IAddr          (iaddr),
        .o_IAck           (iack),
        .o_IRdData        (irdata),
        .i_DReq           (dreq),
        .i_DWrite         (dwrite),
        .i_DAddr          (daddr),
        .i_DWrData        (dwdata),
        .o_DAck           (dack),
        .o_DRdData        (drdata),
        .o_MemReadEnable  (mre),
        .o_MemWriteEnable (mwe),
        .o_MemAddr        (maddr),
        .o_MemWrData      (mwdata),
        .i_MemRdData      (mrdata),
        .o_ConflictCount  (ccount)
    );

    memory_arbiter #(
        .COUNT_WIDTH (4)
    ) u_sat (
        .i_Clock          (clk),
        .i_Reset          (s_rst_n),
        .i_IReq           (1'b1),
        .i_IAddr          (32'h0000_0040),
        .o_IAck           (s_iack),
        .o_IRdData        (s_irdata),
        .i_DReq           (1'b1),
        .i_DWrite         (1'b0),
        .i_DAddr          (32'h0000_0080),
        .i_DWrData        (32'h0000_0000),
        .o_DAck           (s_dack),
        .o_DRdData        (s_drdata),
        .o_MemReadEnable  (s_mre),
        .o_MemWriteEnable (s_mwe),
        .o_MemAddr        (s_maddr),
        .o_MemWrData      (s_mwdata),
        .i_MemRdData      (32'h0000_0000),
        .o_ConflictCount  (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; s_rst_n = 1'b0;
        ireq = 1'b0; dreq = 1'b0; dwrite = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dwdata = 32'h0; mrdata = 32'h0;
        step();
        step();

        // Reset state
        check("rst_acks",  32'({iack, dack}), 32'd0);
        check("rst_en",    32'({mre, mwe}), 32'd0);
        check("rst_addr",  maddr, 32'h0);
        check("rst_wdata", mwdata, 32'h0);
        check("rst_count", 32'(ccount), 32'd0);
        check("rst_sat_outs", 32'(s_iack | s_dack | s_mre | s_mwe | (|s_irdata) | (|s_drdata)
                                  | (|s_maddr) | (|s_mwdata) | (|s_count)), 32'd0);
        rst_n = 1'b1;

        // Single fetch
        ireq = 1'b1; iaddr = 32'h0000_0100;
        step();
        check("fetch_access_re",   32'(mre), 32'd1);
        check("fetch_access_we",   32'(mwe), 32'd0);
        check("fetch_access_addr", maddr, 32'h0000_0100);
        check("fetch_access_noack", 32'(iack), 32'd0);
        step();
        mrdata = 32'h0000_0013;
        #1;
        check("fetch_resp_ack",   32'(iack), 32'd1);
        check("fetch_resp_data",  irdata, 32'h0000_0013);
        check("fetch_resp_dack",  32'(dack), 32'd0);
        check("fetch_resp_re",    32'(mre), 32'd0);
        check("fetch_resp_addr",  maddr, 32'h0);
        ireq = 1'b0;
        step();
        check("fetch_idle_ack",  32'(iack), 32'd0);
        check("fetch_idle_data", irdata, 32'h0);

        // Data write
        dreq = 1'b1; dwrite = 1'b1; daddr = 32'h0000_2000; dwdata = 32'hDEAD_BEEF;
        step();
        check("wr_access_we",    32'(mwe), 32'd1);
        check("wr_access_re",    32'(mre), 32'd0);
        check("wr_access_addr",  maddr, 32'h0000_2000);
        check("wr_access_wdata", mwdata, 32'hDEAD_BEEF);
        step();
        mrdata = 32'h0000_0055;
        #1;
        check("wr_resp_ack",   32'(dack), 32'd1);
        check("wr_resp_rdata", drdata, 32'h0);
        check("wr_resp_we",    32'(mwe), 32'd0);
        check("wr_resp_wdata", mwdata, 32'h0);
        dreq = 1'b0; dwrite = 1'b0;
        step();
        check("wr_idle_ack",   32'(dack), 32'd0);
        check("nocontend_count", 32'(ccount), 32'd0);

        // Data read dropped during ACCESS
        dreq = 1'b1; daddr = 32'h0000_3000;
        step();
        check("drop_access_re",   32'(mre), 32'd1);
        check("drop_access_addr", maddr, 32'h0000_3000);
        dreq = 1'b0; daddr = 32'h0000_4444;
        step();
        mrdata = 32'hCAFE_0001;
        #1;
        check("drop_resp_ack",  32'(dack), 32'd1);
        check("drop_resp_data", drdata, 32'hCAFE_0001);
        check("drop_resp_iack", 32'(iack), 32'd0);
        step();
        check("drop_idle_ack", 32'(dack), 32'd0);
        check("drop_idle_re",  32'(mre), 32'd0);

        // Contention after a fresh reset: I, D, I, D
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        ireq = 1'b1; dreq = 1'b1; dwrite = 1'b0;
        iaddr = 32'h0000_0010; daddr = 32'h0000_0020; mrdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("cont_grant_addr", maddr, (k % 2 == 0) ? 32'h0000_0010 : 32'h0000_0020);
            check("cont_count", 32'(ccount), 32'(k + 1));
            step();
            check("cont_iack", 32'(iack), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_dack", 32'(dack), (k % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check("cont_idle_count", 32'(ccount), 32'(k + 1));
        end
        ireq = 1'b0; dreq = 1'b0;
        step();
        check("cont_quiet_count", 32'(ccount), 32'd4);

        // Reset during ACCESS of a write, then restart with request still held
        dreq = 1'b1; dwrite = 1'b1; daddr = 32'h0000_2000; dwdata = 32'h1234_5678;
        step();
        check("rstw_access_we", 32'(mwe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_we_now",    32'(mwe), 32'd0);
        check("rstw_addr_now",  maddr, 32'h0);
        check("rstw_count_now", 32'(ccount), 32'd0);
        step();
        check("rstw_no_ack", 32'(dack), 32'd0);
        rst_n = 1'b1;
        step();
        check("rstw_restart_we",   32'(mwe), 32'd1);
        check("rstw_restart_data", mwdata, 32'h1234_5678);
        step();
        check("rstw_restart_ack", 32'(dack), 32'd1);
        dreq = 1'b0; dwrite = 1'b0;
        step();

        // Saturation on the 4-bit counter instance
        s_rst_n = 1'b1;
        repeat (42) step();
        check("sat_count_14", 32'(s_count), 32'd14);
        repeat (18) step();
        check("sat_count_hold", 32'(s_count), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
